// File: rtl/seq_1101_tx.sv
// Serial frame transmitter: preamble 1101, DATA_W payload bits MSB first, idle gap.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_1101_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              VALID,
    output logic              READY,
    output logic              OUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
`ifdef SEQ_TX_PARITY_EN
    localparam logic [2:0] S_PAR  = 3'd3;
`endif
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [2:0]       S_END    = (GAP == 0) ? S_IDLE : S_GAP;
    localparam logic [3:0]       PREAMBLE = 4'b1101;
    localparam logic [3:0]       PRE_LAST = 4'd4;
    localparam logic [3:0]       GAP_LAST = 4'(GAP);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);

    logic [2:0]        state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]        aux_cnt_q, aux_cnt_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic              out_q,     out_d;
    logic              done_q,    done_d;
`ifdef SEQ_TX_PARITY_EN
    logic              par_q,     par_d;
`endif

    // OUT is registered from the next state, so the first preamble bit
    // appears in the cycle right after the handshake edge.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        aux_cnt_d = aux_cnt_q;
        shreg_d   = shreg_q;
        out_d     = 1'b0;
        done_d    = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (VALID) begin
                    state_d   = S_PRE;
                    aux_cnt_d = 4'd1;
                    bit_cnt_d = '0;
                    shreg_d   = DATA_IN;
                    out_d     = PREAMBLE[3];
`ifdef SEQ_TX_PARITY_EN
                    par_d     = ^DATA_IN;
`endif
                end
            end
            S_PRE: begin
                if (aux_cnt_q < PRE_LAST) begin
                    out_d     = PREAMBLE[~aux_cnt_q[1:0]];
                    aux_cnt_d = aux_cnt_q + 4'd1;
                end else begin
                    state_d   = S_DATA;
                    out_d     = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = BIT_ONE;
                end
            end
            S_DATA: begin
                if (bit_cnt_q < BIT_LAST) begin
                    out_d     = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d   = S_PAR;
                    out_d     = par_q;
`else
                    state_d   = S_END;
                    aux_cnt_d = 4'd1;
                    done_d    = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PAR: begin
                state_d   = S_END;
                aux_cnt_d = 4'd1;
                done_d    = 1'b1;
            end
`endif
            S_GAP: begin
                if (aux_cnt_q < GAP_LAST) begin
                    aux_cnt_d = aux_cnt_q + 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                aux_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            aux_cnt_q <= '0;
            shreg_q   <= '0;
            out_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            aux_cnt_q <= aux_cnt_d;
            shreg_q   <= shreg_d;
            out_q     <= out_d;
            done_q    <= done_d;
`ifdef SEQ_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign READY = (state_q == S_IDLE);
    assign BUSY  = (state_q != S_IDLE);
    assign OUT   = out_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_seq_1101_tx.sv
// Bench for seq_1101_tx: vector table plus directed multi-cycle sequences.
// A second instance runs with GAP=0 for the back-to-back case.
module tb_seq_1101_tx;

`ifdef SEQ_TX_PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] data, data0;
    logic       valid, valid0;
    logic       ready, out_s, busy, done;
    logic       ready0, out0, busy0, done0;

    int n_cmp;
    int n_bad;

    seq_1101_tx #(.DATA_W(8), .GAP(1)) u_dut (
        .CLK(clk), .RST(rst), .DATA_IN(data), .VALID(valid),
        .READY(ready), .OUT(out_s), .BUSY(busy), .DONE(done)
    );

    seq_1101_tx #(.DATA_W(8), .GAP(0)) u_dut0 (
        .CLK(clk), .RST(rst), .DATA_IN(data0), .VALID(valid0),
        .READY(ready0), .OUT(out0), .BUSY(busy0), .DONE(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       e_out;
        logic       e_done;
        logic       e_ready;
        logic       e_busy;
    } vec_t;

    vec_t vecs[16];
    int   n_vec;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int i);
        logic [3:0] pre;
        pre = 4'b1101;
        if (i < 4) return pre[3-i];
        if (i < 12) return d[11-i];
        return ^d;
    endfunction

    // Starts at a negedge in IDLE, ends at a negedge back in IDLE (GAP=1).
    task automatic do_frame(input logic [7:0] d, input string tag);
        chk({tag, "_ready0"}, 32'(ready), 32'd1);
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
        data  = ~d;
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 32'(out_s), 32'(exp_bit(d, i)));
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'({out_s, done}), 32'b01);
        @(negedge clk);
        chk({tag, "_idle"}, 32'({done, ready}), 32'b01);
    endtask

    task automatic b2b(input int g, input logic [7:0] d1,
                       input logic [7:0] d2, input string tag);
        int second;
        int dn;
        logic e;
        logic a;
        second = FL + g + 2;
        dn = 0;
        if (g == 0) begin valid0 = 1'b1; data0 = d1; end
        else        begin valid  = 1'b1; data  = d1; end
        for (int c = 1; c <= 2 * FL + g + 4; c++) begin
            @(negedge clk);
            if (c <= FL)               e = exp_bit(d1, c - 1);
            else if (c < second)       e = 1'b0;
            else if (c < second + FL)  e = exp_bit(d2, c - second);
            else                       e = 1'b0;
            a = (g == 0) ? out0 : out_s;
            dn += (g == 0) ? int'(done0) : int'(done);
            chk($sformatf("%s_c%0d", tag, c), 32'(a), 32'(e));
            if (g == 0 && c == FL + 1)
                chk({tag, "_gap0_idle"}, 32'({done0, ready0}), 32'b11);
            if (c == 1) begin
                if (g == 0) data0 = d2; else data = d2;
            end
            if (c == second) begin
                if (g == 0) valid0 = 1'b0; else valid = 1'b0;
            end
        end
        chk({tag, "_done_pulses"}, 32'(dn), 32'd2);
    endtask

    initial begin
        int bad;
        logic [FL-1:0] bits;
        logic [7:0] pay;
        n_cmp = 0;
        n_bad = 0;
        rst    = 1'b0;
        valid  = 1'b0;
        valid0 = 1'b0;
        data   = '0;
        data0  = '0;
        repeat (3) @(negedge clk);
        chk("rst_main", 32'({out_s, done, busy, ready}), 32'b0001);
        chk("rst_gap0", 32'({out0, done0, busy0, ready0}), 32'b0001);
        rst = 1'b1;
        @(negedge clk);

`ifdef SEQ_TX_PARITY_EN
        pay  = 8'h07;
        bits = 13'b1101_0000_0111_1;
`else
        pay  = 8'hA5;
        bits = 12'b1101_1010_0101;
`endif
        n_vec = FL + 3;
        vecs[0] = '{1'b1, pay, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i <= FL; i++)
            vecs[i] = '{1'b0, 8'h00, bits[FL-i], 1'b0, 1'b0, 1'b1};
        vecs[FL+1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[FL+2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < n_vec; i++) begin
            chk($sformatf("vec%0d_out", i), 32'(out_s), 32'(vecs[i].e_out));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            valid = vecs[i].valid;
            data  = vecs[i].data;
            @(negedge clk);
        end

        b2b(1, 8'h3C, 8'hC3, "b2b");

        valid = 1'b1;
        data  = 8'hFF;
        @(negedge clk);
        valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("abort_bit%0d", c), 32'(out_s), 32'(exp_bit(8'hFF, c - 1)));
            if (c == 6) rst = 1'b0;
            @(negedge clk);
        end
        chk("abort_c7", 32'({out_s, busy, ready, done}), 32'b0010);
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (done !== 1'b0 || out_s !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("abort_quiet", 32'(bad), 32'd0);
        do_frame(8'h5A, "post_abort");

        rst   = 1'b0;
        valid = 1'b1;
        data  = 8'h69;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d", c), 32'({out_s, busy, done}), 32'b000);
        end
        rst = 1'b1;
        do_frame(8'h96, "after_rst");

        b2b(0, 8'h00, 8'h00, "gap0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
